// File: rtl/vec_exec_v2.sv
// vec_exec_v2 -- multi-cycle vector integer ALU.
//
// Accepts one vector operation when start && ready. All operands are captured
// on the accepting edge. NUM_PE elements (one group) are processed per EXEC
// cycle. A one-cycle DONE state then pulses vec_op_done with the final result.
// vec_exec_out is preloaded with old_vd on accept. Inactive elements (tail,
// masked-off, illegal op) therefore keep their prior destination value.
//
// Parameters:
//   VLEN    vector register width in bits (multiple of 64)
//   NUM_PE  elements processed per cycle (power of 2, 1..VLEN/64)
//
// Ports:
//   clk           clock, rising edge
//   reset_n       synchronous active-low reset
//   start         operation request, accepted when start && ready
//   ready         high only while idle
//   vsew          element width code: 000=8, 001=16, 010=32, 011=64, 1xx illegal
//   funct6        opcode: add, sub, and, or, xor, minu, maxu
//   vl            requested active element count (clamped to VLEN/SEW)
//   operand_a/b   source vectors
//   old_vd        prior destination value
//   mask          per-element enable (used only with VEC_EXEC_MASK_EN)
//   vec_exec_out  result register
//   vec_op_done   one-cycle completion pulse
//   busy          high while executing or completing
//   illegal_op    illegal vsew/funct6 flag, valid with vec_op_done
//
// Build option: define VEC_EXEC_MASK_EN to honour the mask input. Otherwise
// every element below the effective vl is written.
module vec_exec_v2 #(
  parameter int VLEN   = 256,
  parameter int NUM_PE = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      ready,
  input  logic [2:0]                vsew,
  input  logic [5:0]                funct6,
  input  logic [$clog2(VLEN/8):0]   vl,
  input  logic [VLEN-1:0]           operand_a,
  input  logic [VLEN-1:0]           operand_b,
  input  logic [VLEN-1:0]           old_vd,
  input  logic [VLEN/8-1:0]         mask,
  output logic [VLEN-1:0]           vec_exec_out,
  output logic                      vec_op_done,
  output logic                      busy,
  output logic                      illegal_op
);

  localparam int NE  = VLEN / 8;          // max elements (SEW = 8)
  localparam int VLW = $clog2(NE) + 1;    // width of vl / element indices
  localparam int LW  = $clog2(VLEN);      // width of a bit offset
  localparam int PEB = $clog2(NUM_PE);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b001001;
  localparam logic [5:0] OP_OR   = 6'b001010;
  localparam logic [5:0] OP_XOR  = 6'b001011;
  localparam logic [5:0] OP_MINU = 6'b000100;
  localparam logic [5:0] OP_MAXU = 6'b000110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_legal_f(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MINU, OP_MAXU: op_legal_f = 1'b1;
      default: op_legal_f = 1'b0;
    endcase
  endfunction

  // Operands arrive zero-extended to 64 bits. Truncating the result to SEW
  // gives modulo-2^SEW add/sub, and the unsigned compare stays exact.
  function automatic logic [63:0] alu_f(input logic [5:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_MINU: alu_f = (a < b) ? a : b;
      OP_MAXU: alu_f = (a < b) ? b : a;
      default: alu_f = 64'd0;
    endcase
  endfunction

  state_t            r_state;
  logic [VLEN-1:0]   r_out;
  logic              r_done;
  logic              r_ill;
  logic              r_ready;
  logic              r_busy;
  logic [VLW-1:0]    r_grp;

  logic [1:0]        r_sew;
  logic [5:0]        r_funct6;
  logic [VLW-1:0]    r_vl_eff;
  logic [VLW-1:0]    r_last;
  logic              r_illegal;
  logic [VLEN-1:0]   r_a;
  logic [VLEN-1:0]   r_b;

  logic              w_accept;
  logic              w_illegal_in;
  logic [VLW-1:0]    w_vlmax;
  logic [VLW-1:0]    w_vl_eff_in;
  logic [VLW-1:0]    w_last_in;

  logic [VLEN-1:0]   w_next;
  logic [VLW-1:0]    w_base;
  logic [VLW-1:0]    w_idx;
  logic [LW-1:0]     w_lsb;
  logic [63:0]       w_res;
  logic              w_en;

`ifdef VEC_EXEC_MASK_EN
  logic [NE-1:0]       r_mask;
  logic [2**VLW-1:0]   w_mask_x;
  // Widen the mask so any element index in range of w_idx can select a bit.
  assign w_mask_x = {{(2**VLW-NE){1'b0}}, r_mask};
`else
  logic w_unused_mask;
  assign w_unused_mask = ^mask;
`endif

  assign w_accept = start && r_ready && (r_state == S_IDLE);

  // Decode the incoming request: legality, clamped vl and last group index.
  always_comb begin
    w_vlmax = VLW'(NE) >> vsew[1:0];
    if (vsew[2] || !op_legal_f(funct6)) begin
      w_illegal_in = 1'b1;
      w_vl_eff_in  = {VLW{1'b0}};
    end else begin
      w_illegal_in = 1'b0;
      if (vl > w_vlmax) begin
        w_vl_eff_in = w_vlmax;
      end else begin
        w_vl_eff_in = vl;
      end
    end
    // vl_eff = 0 still runs a single (empty) group.
    if (w_vl_eff_in == {VLW{1'b0}}) begin
      w_last_in = {VLW{1'b0}};
    end else begin
      w_last_in = (w_vl_eff_in - VLW'(1)) >> PEB;
    end
  end

  // Result vector after processing the current group of NUM_PE elements.
  always_comb begin
    w_next = r_out;
    w_base = r_grp << PEB;
    w_idx  = {VLW{1'b0}};
    w_lsb  = {LW{1'b0}};
    w_res  = 64'd0;
    w_en   = 1'b0;
    for (int p = 0; p < NUM_PE; p++) begin
      w_idx = w_base + VLW'(p);
`ifdef VEC_EXEC_MASK_EN
      w_en  = (w_idx < r_vl_eff) && w_mask_x[w_idx];
`else
      w_en  = (w_idx < r_vl_eff);
`endif
      w_lsb = (LW'(w_idx) << r_sew) << 2'd3;
      if (w_en) begin
        case (r_sew)
          2'b00: begin
            w_res = alu_f(r_funct6, {56'd0, r_a[w_lsb +: 8]}, {56'd0, r_b[w_lsb +: 8]});
            w_next[w_lsb +: 8] = w_res[7:0];
          end
          2'b01: begin
            w_res = alu_f(r_funct6, {48'd0, r_a[w_lsb +: 16]}, {48'd0, r_b[w_lsb +: 16]});
            w_next[w_lsb +: 16] = w_res[15:0];
          end
          2'b10: begin
            w_res = alu_f(r_funct6, {32'd0, r_a[w_lsb +: 32]}, {32'd0, r_b[w_lsb +: 32]});
            w_next[w_lsb +: 32] = w_res[31:0];
          end
          default: begin
            w_res = alu_f(r_funct6, r_a[w_lsb +: 64], r_b[w_lsb +: 64]);
            w_next[w_lsb +: 64] = w_res;
          end
        endcase
      end else begin
        w_res = 64'd0;
      end
    end
  end

  // Capture the operation on the accepting edge; held until the next accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sew     <= vsew[1:0];
      r_funct6  <= funct6;
      r_vl_eff  <= w_vl_eff_in;
      r_last    <= w_last_in;
      r_illegal <= w_illegal_in;
      r_a       <= operand_a;
      r_b       <= operand_b;
`ifdef VEC_EXEC_MASK_EN
      r_mask    <= mask;
`endif
    end else begin
      r_sew     <= r_sew;
    end
  end

  // Control FSM with result register and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_out   <= {VLEN{1'b0}};
      r_done  <= 1'b0;
      r_ill   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_grp   <= {VLW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_EXEC;
            r_out   <= old_vd;
            r_grp   <= {VLW{1'b0}};
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_out <= w_next;
          if (r_grp == r_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_ill   <= r_illegal;
          end else begin
            r_grp <= r_grp + VLW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ill   <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_grp   <= {VLW{1'b0}};
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ill   <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_grp   <= {VLW{1'b0}};
        end
      endcase
    end
  end

  assign ready        = r_ready;
  assign busy         = r_busy;
  assign vec_op_done  = r_done;
  assign illegal_op   = r_ill;
  assign vec_exec_out = r_out;

endmodule

// File: tb/tb_vec_exec_v2.sv
module tb_vec_exec_v2;
  localparam int VLEN   = 256;
  localparam int NUM_PE = 4;
  localparam int NE     = VLEN / 8;
  localparam int VLW    = $clog2(NE) + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              ready;
  logic [2:0]        vsew;
  logic [5:0]        funct6;
  logic [VLW-1:0]    vl;
  logic [VLEN-1:0]   operand_a, operand_b, old_vd;
  logic [NE-1:0]     mask;
  logic [VLEN-1:0]   vec_exec_out;
  logic              vec_op_done, busy, illegal_op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vec_exec_v2 #(.VLEN(VLEN), .NUM_PE(NUM_PE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready),
    .vsew(vsew), .funct6(funct6), .vl(vl),
    .operand_a(operand_a), .operand_b(operand_b), .old_vd(old_vd), .mask(mask),
    .vec_exec_out(vec_exec_out), .vec_op_done(vec_op_done), .busy(busy),
    .illegal_op(illegal_op)
  );

  // ---------------- reference model ----------------
  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int k = 0; k < VLEN / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic bit ref_legal(input logic [2:0] sv, input logic [5:0] f);
    if (sv > 3'd3) return 1'b0;
    return (f == 6'd0 || f == 6'd2 || f == 6'd9 || f == 6'd10 ||
            f == 6'd11 || f == 6'd4 || f == 6'd6);
  endfunction

  function automatic int ref_vle(input logic [2:0] sv, input logic [VLW-1:0] l);
    int sew, vlmax;
    sew = 8 << sv;
    vlmax = VLEN / sew;
    return (int'(l) > vlmax) ? vlmax : int'(l);
  endfunction

  function automatic int ref_lat(input logic [2:0] sv, input logic [5:0] f,
                                 input logic [VLW-1:0] l);
    int vle;
    if (!ref_legal(sv, f)) return 2;
    vle = ref_vle(sv, l);
    if (vle == 0) return 2;
    return (vle + NUM_PE - 1) / NUM_PE + 1;
  endfunction

  function automatic logic [VLEN-1:0] ref_out(input logic [2:0] sv, input logic [5:0] f,
      input logic [VLW-1:0] l, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
      input logic [VLEN-1:0] o, input logic [NE-1:0] m);
    logic [VLEN-1:0] r, fm;
    logic [63:0] ea, eb, res, emask;
    int sew, vle;
    r = o;
    if (!ref_legal(sv, f)) return r;
    sew = 8 << sv;
    vle = ref_vle(sv, l);
    emask = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
    for (int i = 0; i < vle; i++) begin
`ifdef VEC_EXEC_MASK_EN
      if (!m[i]) continue;
`endif
      ea = 64'(a >> (i * sew)) & emask;
      eb = 64'(b >> (i * sew)) & emask;
      case (f)
        6'd0:  res = ea + eb;
        6'd2:  res = ea - eb;
        6'd9:  res = ea & eb;
        6'd10: res = ea | eb;
        6'd11: res = ea ^ eb;
        6'd4:  res = (ea < eb) ? ea : eb;
        6'd6:  res = (ea > eb) ? ea : eb;
        default: res = 64'd0;
      endcase
      res = res & emask;
      fm = VLEN'(emask) << (i * sew);
      r = (r & ~fm) | (VLEN'(res) << (i * sew));
    end
    return r;
  endfunction

  // Issue one op from IDLE; returns done latency (cycles after accept, -1 on
  // timeout), the result and illegal flag seen in the done cycle. Inputs are
  // scrambled right after acceptance to prove they were latched.
  task automatic run_op(input logic [2:0] sv, input logic [5:0] f, input logic [VLW-1:0] l,
                        input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                        input logic [VLEN-1:0] o, input logic [NE-1:0] m,
                        output int lat, output logic [VLEN-1:0] res, output logic ill);
    vsew = sv; funct6 = f; vl = l; operand_a = a; operand_b = b; old_vd = o; mask = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vsew = 3'($urandom()); funct6 = 6'($urandom()); vl = VLW'($urandom());
    operand_a = rand_vec(); operand_b = rand_vec(); old_vd = rand_vec(); mask = NE'($urandom());
    lat = 1;
    while (!vec_op_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = vec_exec_out;
    ill = illegal_op;
    if (!vec_op_done) lat = -1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (vec_op_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", vec_op_done); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
    checks++; if (vec_exec_out !== {VLEN{1'b0}}) begin errors++; $display("FAIL reset_out: got %h want 0", vec_exec_out); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b want 1/0", ready, busy); end
  endtask

  task automatic test_add32();
    logic [VLEN-1:0] a, b, o, exp, res; logic ill; int lat;
    o = rand_vec();
    for (int i = 0; i < 8; i++) begin
      a[i*32 +: 32] = 32'(i + 1);
      b[i*32 +: 32] = 32'h10;
    end
    exp = ref_out(3'b010, 6'd0, VLW'(8), a, b, o, NE'(0));
    run_op(3'b010, 6'd0, VLW'(8), a, b, o, NE'(0), lat, res, ill);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add32_latency: got %0d want 3", lat); end
    checks++; if (res !== exp) begin errors++; $display("FAIL add32_out: got %h want %h", res, exp); end
    checks++; if (res[31:0] !== 32'h11 || res[255:224] !== 32'h18) begin errors++; $display("FAIL add32_ends: got %h/%h want 11/18", res[31:0], res[255:224]); end
  endtask

  task automatic test_sub8();
    logic [VLEN-1:0] a, b, o, res; logic ill; int lat;
    a = {VLEN{1'b0}};
    b = {NE{8'h01}};
    o = {NE{8'hAA}};
    run_op(3'b000, 6'd2, VLW'(5), a, b, o, NE'(0), lat, res, ill);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sub8_latency: got %0d want 3", lat); end
    checks++; if (res !== {{27{8'hAA}}, {5{8'hFF}}}) begin errors++; $display("FAIL sub8_out: got %h", res); end
  endtask

  task automatic test_mask();
    logic [VLEN-1:0] a, b, o, exp, res; logic [63:0] e1; logic ill; int lat;
    a = rand_vec(); b = rand_vec(); o = rand_vec();
    exp = ref_out(3'b011, 6'd11, VLW'(4), a, b, o, NE'(4'b0101));
`ifdef VEC_EXEC_MASK_EN
    e1 = o[127:64];
`else
    e1 = a[127:64] ^ b[127:64];
`endif
    run_op(3'b011, 6'd11, VLW'(4), a, b, o, NE'(4'b0101), lat, res, ill);
    checks++; if (lat !== 2) begin errors++; $display("FAIL mask_latency: got %0d want 2", lat); end
    checks++; if (res !== exp) begin errors++; $display("FAIL mask_out: got %h want %h", res, exp); end
    checks++; if (res[127:64] !== e1 || res[63:0] !== (a[63:0] ^ b[63:0])) begin errors++; $display("FAIL mask_elem: got %h want %h", res[127:0], {e1, a[63:0] ^ b[63:0]}); end
  endtask

  task automatic test_illegal();
    logic [VLEN-1:0] a, b, o, res; logic ill; int lat;
    for (int k = 0; k < 2; k++) begin
      a = rand_vec(); b = rand_vec(); o = rand_vec();
      if (k == 0) run_op(3'b100, 6'd0, VLW'(8), a, b, o, {NE{1'b1}}, lat, res, ill);
      else        run_op(3'b010, 6'h3F, VLW'(8), a, b, o, {NE{1'b1}}, lat, res, ill);
      checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_latency[%0d]: got %0d want 2", k, lat); end
      checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal_flag[%0d]: got %b want 1", k, ill); end
      checks++; if (res !== o) begin errors++; $display("FAIL illegal_out[%0d]: got %h want %h", k, res, o); end
    end
  endtask

  task automatic test_vl_edges();
    logic [VLEN-1:0] a, b, o, exp, res; logic ill; int lat;
    a = rand_vec(); b = rand_vec(); o = rand_vec();
    run_op(3'b010, 6'd0, VLW'(0), a, b, o, {NE{1'b1}}, lat, res, ill);
    checks++; if (lat !== 2) begin errors++; $display("FAIL vl0_latency: got %0d want 2", lat); end
    checks++; if (res !== o || ill !== 1'b0) begin errors++; $display("FAIL vl0_out: got %h ill=%b want %h ill=0", res, ill, o); end
    exp = ref_out(3'b010, 6'd0, VLW'(8), a, b, o, {NE{1'b1}});
    run_op(3'b010, 6'd0, {VLW{1'b1}}, a, b, o, {NE{1'b1}}, lat, res, ill);
    checks++; if (lat !== 3) begin errors++; $display("FAIL vlclamp_latency: got %0d want 3", lat); end
    checks++; if (res !== exp) begin errors++; $display("FAIL vlclamp_out: got %h want %h", res, exp); end
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'd0, 6'd2, 6'd9, 6'd10, 6'd11, 6'd4, 6'd6};
    logic [VLEN-1:0] a, b, o, exp, res; logic [NE-1:0] m;
    logic [2:0] sv; logic [5:0] f; logic [VLW-1:0] l; logic ill; int lat, elat;
    for (int n = 0; n < 40; n++) begin
      sv = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      f  = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 6)];
      l  = VLW'($urandom_range(0, 2**VLW - 1));
      a = rand_vec(); b = rand_vec(); o = rand_vec(); m = NE'($urandom());
      exp  = ref_out(sv, f, l, a, b, o, m);
      elat = ref_lat(sv, f, l);
      run_op(sv, f, l, a, b, o, m, lat, res, ill);
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d (sew=%b f=%h vl=%0d)", n, lat, elat, sv, f, l); end
      checks++; if (res !== exp) begin errors++; $display("FAIL rand%0d_out: got %h want %h", n, res, exp); end
      checks++; if (ill !== !ref_legal(sv, f)) begin errors++; $display("FAIL rand%0d_illegal: got %b want %b", n, ill, !ref_legal(sv, f)); end
      checks++; if (vec_op_done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL rand%0d_pulse: got done=%b ready=%b want 0/1", n, vec_op_done, ready); end
    end
  endtask

  task automatic test_reset_mid();
    int saw_done;
    saw_done = 0;
    vsew = 3'b000; funct6 = 6'd0; vl = VLW'(32);
    operand_a = rand_vec(); operand_b = rand_vec(); old_vd = rand_vec(); mask = {NE{1'b1}};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (vec_op_done) saw_done++;
    @(posedge clk); #1;
    if (vec_op_done) saw_done++;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got ready=%b busy=%b want 1/0", ready, busy); end
    checks++; if (vec_exec_out !== {VLEN{1'b0}}) begin errors++; $display("FAIL abort_out: got %h want 0", vec_exec_out); end
    for (int c = 0; c < 12; c++) begin
      if (vec_op_done) saw_done++;
      @(posedge clk); #1;
    end
    checks++; if (saw_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", saw_done); end
  endtask

  task automatic test_back_to_back();
    logic [VLEN-1:0] a1, b1, o1, a2, b2, o2, e1, e2;
    int cyc, d1, d2, l2;
    a1 = rand_vec(); b1 = rand_vec(); o1 = rand_vec();
    a2 = rand_vec(); b2 = rand_vec(); o2 = rand_vec();
    e1 = ref_out(3'b010, 6'd0, VLW'(8), a1, b1, o1, {NE{1'b1}});
    e2 = ref_out(3'b000, 6'd2, VLW'(5), a2, b2, o2, {NE{1'b1}});
    l2 = ref_lat(3'b000, 6'd2, VLW'(5));
    vsew = 3'b010; funct6 = 6'd0; vl = VLW'(8);
    operand_a = a1; operand_b = b1; old_vd = o1; mask = {NE{1'b1}};
    start = 1'b1;
    @(posedge clk); #1;
    vsew = 3'b000; funct6 = 6'd2; vl = VLW'(5);
    operand_a = a2; operand_b = b2; old_vd = o2;
    cyc = 1;
    while (!vec_op_done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    d1 = vec_op_done ? cyc : -1;
    checks++; if (d1 !== 3) begin errors++; $display("FAIL b2b_first_latency: got %0d want 3", d1); end
    checks++; if (vec_exec_out !== e1) begin errors++; $display("FAIL b2b_first_out: got %h want %h", vec_exec_out, e1); end
    @(posedge clk); #1; cyc++;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_gap: got %b want 1", ready); end
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    while (!vec_op_done && cyc < 80) begin @(posedge clk); #1; cyc++; end
    d2 = vec_op_done ? cyc : -1;
    checks++; if (d2 !== d1 + 1 + l2) begin errors++; $display("FAIL b2b_second_done: got %0d want %0d", d2, d1 + 1 + l2); end
    checks++; if (vec_exec_out !== e2) begin errors++; $display("FAIL b2b_second_out: got %h want %h", vec_exec_out, e2); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; vsew = 3'b000; funct6 = 6'd0; vl = {VLW{1'b0}};
    operand_a = {VLEN{1'b0}}; operand_b = {VLEN{1'b0}}; old_vd = {VLEN{1'b0}}; mask = {NE{1'b0}};
    test_reset();
    test_add32();
    test_sub8();
    test_mask();
    test_illegal();
    test_vl_edges();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
